// File: rtl/fp16_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_div_pkg
// Description : Shared widths, FSM states and error quotient for fp16_div_sched
// Revision    : 1.0
// ============================================================================
package fp16_div_pkg;

    localparam int          FP16_W     = 16;
    localparam logic [15:0] FP16_ERR_Q = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_div_sched_if
// Description : Requester fabric and response channel of the divider scheduler
// Revision    : 1.0
// ============================================================================
interface fp16_div_sched_if
    import fp16_div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [FP16_W*NUM_REQ-1:0] req_dividend;
    logic [FP16_W*NUM_REQ-1:0] req_divisor;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [ID_W-1:0]           resp_id;
    logic [FP16_W-1:0]         resp_q;
    logic                      resp_err;

    modport master (
        output req_valid, req_dividend, req_divisor, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_q, resp_err
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, resp_ready,
        output req_ready, resp_valid, resp_id, resp_q, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority arbiter, scan starts after last grant
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    input  logic             i_enable,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    always_comb begin
        int w_dist;
        int w_best_dist;
        int w_best_idx;
        o_grant     = '0;
        o_grant_idx = '0;
        w_dist      = 0;
        w_best_dist = N;
        w_best_idx  = 0;
        // Distance 0 is the requester right after the last grant
        for (int i = 0; i < N; i++) begin
            w_dist = i - int'(i_last_grant) - 1;
            if (w_dist < 0) w_dist = w_dist + N;
            if (i_req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_idx  = i;
            end
        end
        if (i_enable && (w_best_dist < N)) begin
            o_grant     = N'(1) << w_best_idx;
            o_grant_idx = IDX_W'(w_best_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : fp16_div_sched
// Description : Round-robin sharing of one multicycle FP16 divider with timeout
// Revision    : 1.0
// ============================================================================
module fp16_div_sched
    import fp16_div_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    fp16_div_sched_if.slave   bus,
    output logic              busy,
    output logic              div_input_valid,
    output logic [FP16_W-1:0] div_dividend,
    output logic [FP16_W-1:0] div_divisor,
    input  logic              div_output_update,
    input  logic              div_idle,
    input  logic [FP16_W-1:0] div_q
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_cur_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [FP16_W-1:0]   r_dividend;
    logic [FP16_W-1:0]   r_divisor;
    logic [FP16_W-1:0]   r_resp_q;
    logic [ID_W-1:0]     r_resp_id;
    logic                r_resp_err;
    logic                r_resp_valid;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_arb_en;
    logic                w_timeout;
    logic [FP16_W-1:0]   w_dvd [NUM_REQ];
    logic [FP16_W-1:0]   w_dvs [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_dvd[g] = bus.req_dividend[g*FP16_W +: FP16_W];
        assign w_dvs[g] = bus.req_divisor[g*FP16_W +: FP16_W];
    end

    // No grant on a reset edge so that a request is never half-accepted
    assign w_arb_en  = rst && (r_state == IDLE) && div_idle;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (div_output_update || w_timeout) w_next = RESP;
            RESP:    if (bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_cur_id     <= '0;
            r_cnt        <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_resp_q     <= '0;
            r_resp_id    <= '0;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|w_grant) begin
                    r_dividend <= w_dvd[w_grant_idx];
                    r_divisor  <= w_dvs[w_grant_idx];
                    r_cur_id   <= w_grant_idx;
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A result arriving on the timeout cycle still counts as good
                    if (div_output_update) begin
                        r_resp_q     <= div_q;
                        r_resp_err   <= 1'b0;
                        r_resp_id    <= r_cur_id;
                        r_resp_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_resp_q     <= FP16_ERR_Q;
                        r_resp_err   <= 1'b1;
                        r_resp_id    <= r_cur_id;
                        r_resp_valid <= 1'b1;
                    end
                end
                RESP: if (bus.resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_last_grant <= r_cur_id;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (r_state != IDLE);
    assign div_input_valid = (r_state == ISSUE);
    assign div_dividend    = r_dividend;
    assign div_divisor     = r_divisor;
    assign bus.req_ready   = w_grant;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_q      = r_resp_q;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_err    = r_resp_err;

endmodule
`default_nettype wire
